// File: rtl/median_pkg.sv
// Shared types and frame constants for the median filter front end.
// lbuf_add steps a line-buffer index modulo 3.
package median_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [31:0] word_t;

  localparam int unsigned IMG_WIDTH  = 228;
  localparam int unsigned IMG_HEIGHT = 228;
  localparam int unsigned WPL        = IMG_WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } loader_state_t;

  // Line-buffer index arithmetic; indices live in 0..2 only.
  function automatic logic [1:0] lbuf_add(input logic [1:0] lbuf, input logic [1:0] inc);
    logic [2:0] sum;
    sum = {1'b0, lbuf} + {1'b0, inc};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/median_window_loader_if.sv
// Pixel-beat input stream and 3-row word-triple output stream of the window loader.
// master is the loader side, slave is the environment (source/sink) side.
interface median_window_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  import median_pkg::*;

  logic              in_valid;
  logic              in_ready;
  pixel_t            pixel1;
  pixel_t            pixel2;
  pixel_t            pixel3;
  pixel_t            pixel4;
  word_t             word0;
  word_t             word1;
  word_t             word2;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        window_line_counter;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_valid, pixel1, pixel2, pixel3, pixel4, out_ready,
    output in_ready, word0, word1, word2, waddr, window_line_counter, out_valid
  );

  modport slave (
    output in_valid, pixel1, pixel2, pixel3, pixel4, out_ready,
    input  in_ready, word0, word1, word2, waddr, window_line_counter, out_valid
  );

endinterface

// File: rtl/line_ram.sv
// Simple dual-port line RAM, one image row of 32-bit words.
// Registered read that holds its value while the read enable is low.
module line_ram
  import median_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];
  word_t rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/median_window_loader.sv
// Buffers the two previous image rows in three rotating line RAMs and emits, for every
// beat of rows 2.., the vertically aligned (r-2, r-1, r) word triple for the median core.
module median_window_loader #(
  parameter int unsigned IMG_WIDTH  = median_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = median_pkg::IMG_HEIGHT,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  median_window_loader_if.master bus,
  output logic                  end_of_frame
);

  localparam int unsigned Wpl  = IMG_WIDTH / 4;
  localparam int unsigned RowW = $clog2(IMG_HEIGHT + 1);

  localparam logic [ADDR_W-1:0] LastCol  = ADDR_W'(Wpl - 1);
  localparam logic [RowW-1:0]   LastRow  = RowW'(IMG_HEIGHT - 1);
  localparam logic [RowW-1:0]   FillLast = RowW'(1);

  localparam logic [1:0] StIdle   = median_pkg::IDLE;
  localparam logic [1:0] StFill   = median_pkg::FILL;
  localparam logic [1:0] StStream = median_pkg::STREAM;
  localparam logic [1:0] StDrain  = median_pkg::DRAIN;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [1:0]        lbuf_q, lbuf_d;
  logic              out_valid_q, out_valid_d;
  median_pkg::word_t word2_q, word2_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        wlc_q, wlc_d;
  logic              eof_q, eof_d;

  logic              in_ready;
  logic              accept;
  logic              stream_acc;
  logic              last_col;
  median_pkg::word_t beat;
  median_pkg::word_t rdata [3];
  logic [1:0]        sel_old;
  logic [1:0]        sel_mid;

  assign beat       = {bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4};
  assign accept     = bus.in_valid && in_ready;
  assign stream_acc = accept && (state_q == StStream);
  assign last_col   = (col_q == LastCol);

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StFill:   in_ready = 1'b1;
      StStream: in_ready = !out_valid_q || bus.out_ready;
      default:  in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    lbuf_d      = lbuf_q;
    out_valid_d = out_valid_q;
    word2_d     = word2_q;
    waddr_d     = waddr_q;
    wlc_d       = wlc_q;
    eof_d       = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (stream_acc) begin
      out_valid_d = 1'b1;
      word2_d     = beat;
      waddr_d     = col_q;
      wlc_d       = lbuf_q;
    end

    if (accept) begin
      if (last_col) begin
        col_d  = '0;
        row_d  = row_q + 1'b1;
        lbuf_d = median_pkg::lbuf_add(lbuf_q, 2'd1);
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          col_d   = '0;
          row_d   = '0;
          lbuf_d  = '0;
        end
      end
      StFill: begin
        if (accept && last_col && (row_q == FillLast)) state_d = StStream;
      end
      StStream: begin
        if (accept && last_col && (row_q == LastRow)) state_d = StDrain;
      end
      StDrain: begin
        // Only the final triple is outstanding here.
        if (out_valid_q && bus.out_ready) begin
          state_d = StIdle;
          eof_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      lbuf_q      <= '0;
      out_valid_q <= 1'b0;
      word2_q     <= '0;
      waddr_q     <= '0;
      wlc_q       <= '0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lbuf_q      <= lbuf_d;
      out_valid_q <= out_valid_d;
      word2_q     <= word2_d;
      waddr_q     <= waddr_d;
      wlc_q       <= wlc_d;
      eof_q       <= eof_d;
    end
  end

  // The buffer being written is never read in the same cycle.
  for (genvar i = 0; i < 3; i++) begin : g_ram
    line_ram #(
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && (lbuf_q == 2'(i))),
      .waddr (col_q),
      .wdata (beat),
      .re    (stream_acc && (lbuf_q != 2'(i))),
      .raddr (col_q),
      .rdata (rdata[i])
    );
  end

  assign sel_old = median_pkg::lbuf_add(wlc_q, 2'd1);
  assign sel_mid = median_pkg::lbuf_add(wlc_q, 2'd2);

  always_comb begin
    bus.word0 = rdata[0];
    unique case (sel_old)
      2'd1:    bus.word0 = rdata[1];
      2'd2:    bus.word0 = rdata[2];
      default: bus.word0 = rdata[0];
    endcase
  end

  always_comb begin
    bus.word1 = rdata[0];
    unique case (sel_mid)
      2'd1:    bus.word1 = rdata[1];
      2'd2:    bus.word1 = rdata[2];
      default: bus.word1 = rdata[0];
    endcase
  end

  assign bus.in_ready            = in_ready;
  assign bus.word2               = word2_q;
  assign bus.waddr               = waddr_q;
  assign bus.window_line_counter = wlc_q;
  assign bus.out_valid           = out_valid_q;
  assign end_of_frame            = eof_q;

endmodule

// File: tb/tb_median_window_loader.sv
// Bench for median_window_loader: ramp-image frames with a triple scoreboard, stalls,
// spurious start, drain-time in_valid, async mid-frame reset and a table of fixed triples.
module tb_median_window_loader;
  import median_pkg::*;

  localparam int H      = IMG_HEIGHT;
  localparam int W      = WPL;
  localparam int NTRIP  = (H - 2) * W;
  localparam int BUDGET = 35000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic end_of_frame;

  median_window_loader_if #(.ADDR_W(10)) bus ();

  median_window_loader #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_W     (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .end_of_frame (end_of_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [9:0]  waddr;
    logic [1:0]  wlc;
    logic [31:0] idx;
  } trip_t;

  typedef struct {
    int          row;
    int          col;
    logic [1:0]  wlc;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  trip_t sb[$];
  trip_t cap[int];
  vec_t  vecs[7];
  int    errors = 0;
  int    checks = 0;

  function automatic word_t ramp(input int r, input int c);
    word_t w;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 8'((r + 4 * c + k) % 256);
    return w;
  endfunction

  function automatic trip_t sample_out();
    trip_t t;
    t.w0    = bus.word0;
    t.w1    = bus.word1;
    t.w2    = bus.word2;
    t.waddr = bus.waddr;
    t.wlc   = bus.window_line_counter;
    t.idx   = '0;
    return t;
  endfunction

  task automatic chk(input bit ok, input string name, input string info);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(bus.out_valid === 1'b0 && bus.in_ready === 1'b0 && end_of_frame === 1'b0 &&
        bus.word0 === '0 && bus.word1 === '0 && bus.word2 === '0 &&
        bus.waddr === '0 && bus.window_line_counter === '0, name,
        $sformatf("got ov=%b ir=%b eof=%b w0=%h w1=%h w2=%h wa=%0d wlc=%0d, want all 0",
                  bus.out_valid, bus.in_ready, end_of_frame, bus.word0, bus.word1,
                  bus.word2, bus.waddr, bus.window_line_counter));
  endtask

  task automatic run_frame(input string tag, input bit rnd_in, input bit rnd_out,
                           input int abort_row, input bit spurious, input int idle_cycles);
    int    r = 0;
    int    c = 0;
    int    triples = 0;
    int    eofs = 0;
    int    cyc = 0;
    int    tail = 0;
    bit    done_in = 1'b0;
    bit    stalled = 1'b0;
    bit    fin = 1'b0;
    trip_t held;
    trip_t a;
    trip_t e;
    word_t bw;
    sb.delete();
    cap.delete();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    while (!fin && cyc < BUDGET) begin
      cyc++;
      bus.out_ready = rnd_out ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (done_in) bus.in_valid = 1'b1;
      else if (cyc <= idle_cycles) bus.in_valid = 1'b0;
      else bus.in_valid = rnd_in ? ($urandom_range(0, 7) != 0) : 1'b1;
      bw = done_in ? 32'hDEAD_BEEF : ramp(r, c);
      {bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4} = bw;
      start = spurious && r == 50 && c == 3;
      #1;
      a = sample_out();
      if (stalled)
        chk(bus.out_valid === 1'b1 && a == held, {tag, "_stall_hold"},
            $sformatf("got ov=%b %h/%h/%h wa=%0d, want held %h/%h/%h wa=%0d", bus.out_valid,
                      a.w0, a.w1, a.w2, a.waddr, held.w0, held.w1, held.w2, held.waddr));
      if (cyc <= idle_cycles)
        chk(bus.in_ready === 1'b1 && bus.out_valid === 1'b0, {tag, "_fill_idle"},
            $sformatf("got ir=%b ov=%b, want ir=1 ov=0", bus.in_ready, bus.out_valid));
      if (done_in)
        chk(bus.in_ready === 1'b0, {tag, "_drain_in_ready"},
            $sformatf("got in_ready=%b, want 0", bus.in_ready));
      stalled = bus.out_valid && !bus.out_ready;
      if (stalled) begin
        held = a;
        chk(bus.in_ready === 1'b0, {tag, "_stall_in_ready"},
            $sformatf("got in_ready=%b, want 0", bus.in_ready));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, {tag, "_unexpected_triple"},
              $sformatf("got triple wa=%0d with empty scoreboard, want none", a.waddr));
        end else begin
          e = sb.pop_front();
          triples++;
          a.idx = e.idx;
          cap[int'(e.idx)] = a;
          chk(a.w0 === e.w0 && a.w1 === e.w1 && a.w2 === e.w2 && a.waddr === e.waddr &&
              a.wlc === e.wlc, {tag, "_triple"},
              $sformatf("idx %0d got %h/%h/%h wa=%0d wlc=%0d, want %h/%h/%h wa=%0d wlc=%0d",
                        e.idx, a.w0, a.w1, a.w2, a.waddr, a.wlc,
                        e.w0, e.w1, e.w2, e.waddr, e.wlc));
        end
      end
      if (bus.in_valid && bus.in_ready && !done_in) begin
        if (r >= 2) begin
          e.w0    = ramp(r - 2, c);
          e.w1    = ramp(r - 1, c);
          e.w2    = ramp(r, c);
          e.waddr = 10'(c);
          e.wlc   = 2'(r % 3);
          e.idx   = 32'((r - 2) * W + c);
          sb.push_back(e);
        end
        c++;
        if (c == W) begin
          c = 0;
          r++;
          if (r == H) done_in = 1'b1;
        end
      end
      if (end_of_frame === 1'b1) begin
        eofs++;
        if (tail == 0) tail = 1;
      end
      if (tail > 0) begin
        tail++;
        if (tail > 4) fin = 1'b1;
      end
      if (abort_row >= 0 && r == abort_row) begin
        #2 rst_n = 1'b0;
        #1 chk_zero({tag, "_async_reset"});
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    if (abort_row >= 0) begin
      chk(1'b0, {tag, "_abort_not_reached"}, $sformatf("got row %0d, want %0d", r, abort_row));
      return;
    end
    chk(fin, {tag, "_frame_done"}, $sformatf("got no end_of_frame in %0d cycles", cyc));
    chk(triples == NTRIP, {tag, "_triple_count"},
        $sformatf("got %0d triples, want %0d", triples, NTRIP));
    chk(eofs == 1, {tag, "_eof_pulses"}, $sformatf("got %0d pulses, want 1", eofs));
    chk(sb.size() == 0, {tag, "_sb_leftover"},
        $sformatf("got %0d pending triples, want 0", sb.size()));
  endtask

  task automatic check_vectors(input string tag);
    trip_t a;
    int    idx;
    foreach (vecs[i]) begin
      idx = (vecs[i].row - 2) * W + vecs[i].col;
      if (!cap.exists(idx)) begin
        chk(1'b0, $sformatf("%s_vec%0d", tag, i),
            $sformatf("got no triple at row %0d col %0d", vecs[i].row, vecs[i].col));
      end else begin
        a = cap[idx];
        chk(a.wlc === vecs[i].wlc && a.waddr === 10'(vecs[i].col) && a.w0 === vecs[i].w0 &&
            a.w1 === vecs[i].w1 && a.w2 === vecs[i].w2, $sformatf("%s_vec%0d", tag, i),
            $sformatf("got %h/%h/%h wa=%0d wlc=%0d, want %h/%h/%h wa=%0d wlc=%0d",
                      a.w0, a.w1, a.w2, a.waddr, a.wlc, vecs[i].w0, vecs[i].w1,
                      vecs[i].w2, vecs[i].col, vecs[i].wlc));
      end
    end
  endtask

  initial begin
    vecs[0] = '{2,   0,  2'd2, 32'h0001_0203, 32'h0102_0304, 32'h0203_0405};
    vecs[1] = '{3,   0,  2'd0, 32'h0102_0304, 32'h0203_0405, 32'h0304_0506};
    vecs[2] = '{4,   0,  2'd1, 32'h0203_0405, 32'h0304_0506, 32'h0405_0607};
    vecs[3] = '{5,   0,  2'd2, 32'h0304_0506, 32'h0405_0607, 32'h0506_0708};
    vecs[4] = '{2,   56, 2'd2, 32'hE0E1_E2E3, 32'hE1E2_E3E4, 32'hE2E3_E4E5};
    vecs[5] = '{100, 10, 2'd1, 32'h8A8B_8C8D, 32'h8B8C_8D8E, 32'h8C8D_8E8F};
    vecs[6] = '{227, 56, 2'd2, 32'hC1C2_C3C4, 32'hC2C3_C4C5, 32'hC3C4_C5C6};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4} = 32'h0;
    #3;
    chk_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(bus.in_ready === 1'b0 && bus.out_valid === 1'b0, "idle_no_ready",
        $sformatf("got ir=%b ov=%b, want 0 0", bus.in_ready, bus.out_valid));

    run_frame("f1", 1'b0, 1'b0, -1, 1'b0, 3);
    check_vectors("f1");
    run_frame("f2", 1'b1, 1'b1, -1, 1'b1, 0);
    run_frame("f3", 1'b0, 1'b0, 100, 1'b0, 0);
    run_frame("f4", 1'b0, 1'b1, -1, 1'b0, 0);
    check_vectors("f4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
